ysyx_210544_mem_stage: RTL and testbench

Memory-access pipeline stage sitting between execute and writeback. It accepts one instruction per execute handshake and performs at most one data-memory load or store through a simple request/ready port. Load data is aligned and sign/zero-extended, and store data and mask are lane-shifted. The stage then presents the instruction to writeback with the same req/ack handshake writeback uses.

---
 rtl/ysyx_210544_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_ysyx_210544_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_mem_stage.sv
// Memory-access pipeline stage: one load/store per instruction over a req/ready
// data port, with lane-shifted store data/mask and aligned, extended load data.
module ysyx_210544_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_executed_req,
    output logic        o_mem_executed_ack,
    output logic        o_mem_memoryed_req,
    input  logic        i_mem_memoryed_ack,
    input  logic [63:0] i_mem_pc,
    input  logic [31:0] i_mem_inst,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_rd_wen,
    input  logic [63:0] i_mem_rd_wdata,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_mem_funct3,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_wdata,
    input  logic        i_mem_skipcmt,
    input  logic [31:0] i_mem_intrNo,
    output logic [63:0] o_mem_pc,
    output logic [31:0] o_mem_inst,
    output logic [4:0]  o_mem_rd,
    output logic        o_mem_rd_wen,
    output logic [63:0] o_mem_rd_wdata,
    output logic        o_mem_skipcmt,
    output logic [31:0] o_mem_intrNo,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [63:0] o_dmem_addr,
    output logic [63:0] o_dmem_wdata,
    output logic [7:0]  o_dmem_wmask,
    output logic [1:0]  o_dmem_size,
    input  logic [63:0] i_dmem_rdata,
    input  logic        i_dmem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_next;

    logic [63:0] pc_r;
    logic [31:0] inst_r;
    logic [4:0]  rd_r;
    logic        rd_wen_r;
    logic [63:0] rd_wdata_r;
    logic        ren_r;
    logic        wen_r;
    logic [2:0]  funct3_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic        skipcmt_r;
    logic [31:0] intrno_r;
    logic [63:0] load_r;

    logic [2:0]  off;
    logic [7:0]  mask_base;
    logic [15:0] mask_wide;
    logic [63:0] raw;
    logic [63:0] load_ext;
    logic        is_load;

    assign off     = addr_r[2:0];
    assign is_load = ren_r & ~wen_r;

    always_comb begin
        mask_base = 8'h01;
        case (funct3_r[1:0])
            2'b00: mask_base = 8'h01;
            2'b01: mask_base = 8'h03;
            2'b10: mask_base = 8'h0F;
            2'b11: mask_base = 8'hFF;
            default: mask_base = 8'h01;
        endcase
        // widened so lanes shifted past byte 7 fall off instead of wrapping
        mask_wide = {8'h00, mask_base} << off;
    end

    always_comb begin
        raw      = i_dmem_rdata >> {off, 3'b000};
        load_ext = raw;
        case (funct3_r)
            3'b000:  load_ext = {{56{raw[7]}},  raw[7:0]};
            3'b001:  load_ext = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_ext = {{32{raw[31]}}, raw[31:0]};
            3'b100:  load_ext = {56'd0, raw[7:0]};
            3'b101:  load_ext = {48'd0, raw[15:0]};
            3'b110:  load_ext = {32'd0, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_mem_executed_req) state_next = (i_mem_ren | i_mem_wen) ? ACCESS : DONE;
            ACCESS:  if (i_dmem_ready)       state_next = DONE;
            DONE:    if (i_mem_memoryed_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r       <= '0;
            inst_r     <= '0;
            rd_r       <= '0;
            rd_wen_r   <= 1'b0;
            rd_wdata_r <= '0;
            ren_r      <= 1'b0;
            wen_r      <= 1'b0;
            funct3_r   <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            skipcmt_r  <= 1'b0;
            intrno_r   <= '0;
            load_r     <= '0;
        end else begin
            if (state == IDLE && i_mem_executed_req) begin
                pc_r       <= i_mem_pc;
                inst_r     <= i_mem_inst;
                rd_r       <= i_mem_rd;
                rd_wen_r   <= i_mem_rd_wen;
                rd_wdata_r <= i_mem_rd_wdata;
                ren_r      <= i_mem_ren;
                wen_r      <= i_mem_wen;
                funct3_r   <= i_mem_funct3;
                addr_r     <= i_mem_addr;
                wdata_r    <= i_mem_wdata;
                skipcmt_r  <= i_mem_skipcmt;
                intrno_r   <= i_mem_intrNo;
            end
            if (state == ACCESS && i_dmem_ready) begin
                load_r <= load_ext;
            end
        end
    end

    always_comb begin
        o_mem_executed_ack = (state == IDLE);
        o_dmem_req         = (state == ACCESS);
        o_dmem_wen         = wen_r;
        o_dmem_addr        = {addr_r[63:3], 3'b000};
        o_dmem_wdata       = wdata_r << {off, 3'b000};
        o_dmem_wmask       = mask_wide[7:0];
        o_dmem_size        = funct3_r[1:0];
        o_mem_memoryed_req = 1'b0;
        o_mem_pc           = '0;
        o_mem_inst         = '0;
        o_mem_rd           = '0;
        o_mem_rd_wen       = 1'b0;
        o_mem_rd_wdata     = '0;
        o_mem_skipcmt      = 1'b0;
        o_mem_intrNo       = '0;
        if (state == DONE) begin
            o_mem_memoryed_req = 1'b1;
            o_mem_pc           = pc_r;
            o_mem_inst         = inst_r;
            o_mem_rd           = rd_r;
            o_mem_rd_wen       = rd_wen_r;
            o_mem_rd_wdata     = is_load ? load_r : rd_wdata_r;
            o_mem_skipcmt      = skipcmt_r;
            o_mem_intrNo       = intrno_r;
        end
    end

endmodule

// File: tb/tb_ysyx_210544_mem_stage.sv
// Randomized bench for ysyx_210544_mem_stage with an arithmetic reference model
// of lane masking, store shifting and load extension.
module tb_ysyx_210544_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_mem_executed_req = 1'b0;
    logic        o_mem_executed_ack;
    logic        o_mem_memoryed_req;
    logic        i_mem_memoryed_ack = 1'b0;
    logic [63:0] i_mem_pc = '0;
    logic [31:0] i_mem_inst = '0;
    logic [4:0]  i_mem_rd = '0;
    logic        i_mem_rd_wen = 1'b0;
    logic [63:0] i_mem_rd_wdata = '0;
    logic        i_mem_ren = 1'b0;
    logic        i_mem_wen = 1'b0;
    logic [2:0]  i_mem_funct3 = '0;
    logic [63:0] i_mem_addr = '0;
    logic [63:0] i_mem_wdata = '0;
    logic        i_mem_skipcmt = 1'b0;
    logic [31:0] i_mem_intrNo = '0;
    logic [63:0] o_mem_pc;
    logic [31:0] o_mem_inst;
    logic [4:0]  o_mem_rd;
    logic        o_mem_rd_wen;
    logic [63:0] o_mem_rd_wdata;
    logic        o_mem_skipcmt;
    logic [31:0] o_mem_intrNo;
    logic        o_dmem_req;
    logic        o_dmem_wen;
    logic [63:0] o_dmem_addr;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_wmask;
    logic [1:0]  o_dmem_size;
    logic [63:0] i_dmem_rdata = '0;
    logic        i_dmem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_210544_mem_stage dut (
        .clk(clk), .rst(rst),
        .i_mem_executed_req(i_mem_executed_req), .o_mem_executed_ack(o_mem_executed_ack),
        .o_mem_memoryed_req(o_mem_memoryed_req), .i_mem_memoryed_ack(i_mem_memoryed_ack),
        .i_mem_pc(i_mem_pc), .i_mem_inst(i_mem_inst), .i_mem_rd(i_mem_rd),
        .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_wdata(i_mem_rd_wdata),
        .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_funct3(i_mem_funct3),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_mem_skipcmt(i_mem_skipcmt), .i_mem_intrNo(i_mem_intrNo),
        .o_mem_pc(o_mem_pc), .o_mem_inst(o_mem_inst), .o_mem_rd(o_mem_rd),
        .o_mem_rd_wen(o_mem_rd_wen), .o_mem_rd_wdata(o_mem_rd_wdata),
        .o_mem_skipcmt(o_mem_skipcmt), .o_mem_intrNo(o_mem_intrNo),
        .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wmask(o_dmem_wmask), .o_dmem_size(o_dmem_size),
        .i_dmem_rdata(i_dmem_rdata), .i_dmem_ready(i_dmem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [7:0] mdl_mask(input logic [2:0] f3, input logic [63:0] addr);
        int nbytes = 1 << f3[1:0];
        logic [15:0] m = ((16'd1 << nbytes) - 16'd1) << addr[2:0];
        return m[7:0];
    endfunction

    function automatic logic [63:0] mdl_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdata);
        logic [63:0] raw = rdata >> (8 * addr[2:0]);
        int bits = 8 * (1 << f3[1:0]);
        logic [63:0] keep;
        logic [63:0] v;
        if (bits == 64) return raw;
        keep = (64'd1 << bits) - 64'd1;
        v = raw & keep;
        if (!f3[2] && raw[bits-1]) v = v | ~keep;
        return v;
    endfunction

    task automatic scramble_inputs();
        i_mem_pc       = rnd64();
        i_mem_inst     = $urandom;
        i_mem_rd       = 5'($urandom);
        i_mem_rd_wen   = 1'($urandom);
        i_mem_rd_wdata = rnd64();
        i_mem_ren      = 1'($urandom);
        i_mem_wen      = 1'($urandom);
        i_mem_funct3   = 3'($urandom);
        i_mem_addr     = rnd64();
        i_mem_wdata    = rnd64();
        i_mem_skipcmt  = 1'($urandom);
        i_mem_intrNo   = $urandom;
    endtask

    // One full instruction; a competing execute request with unrelated data is held
    // through ACCESS/DONE, and stray ready/ack pulses are injected where they must be ignored.
    task automatic run_txn(input logic ren, input logic wen, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] alu, input logic [63:0] rdata,
                           input logic [63:0] pc, input logic [4:0] rd,
                           input int unsigned lat, input int unsigned stall);
        logic [31:0] inst   = $urandom;
        logic        rd_wen = 1'($urandom);
        logic        skip   = 1'($urandom);
        logic [31:0] intr   = $urandom;
        logic        mem    = ren | wen;
        logic [63:0] exp_res = (ren && !wen) ? mdl_load(f3, addr, rdata) : alu;

        i_mem_pc = pc; i_mem_inst = inst; i_mem_rd = rd; i_mem_rd_wen = rd_wen;
        i_mem_rd_wdata = alu; i_mem_ren = ren; i_mem_wen = wen; i_mem_funct3 = f3;
        i_mem_addr = addr; i_mem_wdata = wdata; i_mem_skipcmt = skip; i_mem_intrNo = intr;
        i_mem_executed_req = 1'b1;
        check("idle_exec_ack", o_mem_executed_ack, 1);
        check("idle_dmem_req", o_dmem_req, 0);
        check("idle_wb_req", o_mem_memoryed_req, 0);
        tick();
        scramble_inputs();
        if (mem) begin
            for (int unsigned c = 0; c < lat; c++) begin
                check("acc_dmem_req", o_dmem_req, 1);
                check("acc_exec_ack", o_mem_executed_ack, 0);
                check("acc_wb_req", o_mem_memoryed_req, 0);
                check("acc_wb_wdata", o_mem_rd_wdata, 0);
                check("acc_wb_intr", o_mem_intrNo, 0);
                check("acc_addr", o_dmem_addr, {addr[63:3], 3'b000});
                check("acc_wmask", o_dmem_wmask, mdl_mask(f3, addr));
                check("acc_wdata", o_dmem_wdata, wdata << (8 * addr[2:0]));
                check("acc_wen", o_dmem_wen, wen);
                check("acc_size", o_dmem_size, f3[1:0]);
                i_mem_memoryed_ack = 1'($urandom);
                if (c == lat - 1) begin
                    i_dmem_ready = 1'b1;
                    i_dmem_rdata = rdata;
                end else begin
                    i_dmem_ready = 1'b0;
                    i_dmem_rdata = rnd64();
                end
                tick();
            end
            i_dmem_ready = 1'b0;
        end
        i_mem_memoryed_ack = 1'b0;
        for (int unsigned c = 0; c <= stall; c++) begin
            check("done_dmem_req", o_dmem_req, 0);
            check("done_wb_req", o_mem_memoryed_req, 1);
            check("done_exec_ack", o_mem_executed_ack, 0);
            check("done_pc", o_mem_pc, pc);
            check("done_inst", o_mem_inst, inst);
            check("done_rd", o_mem_rd, rd);
            check("done_rd_wen", o_mem_rd_wen, rd_wen);
            check("done_rd_wdata", o_mem_rd_wdata, exp_res);
            check("done_skipcmt", o_mem_skipcmt, skip);
            check("done_intr", o_mem_intrNo, intr);
            i_dmem_ready = 1'($urandom);
            i_dmem_rdata = rnd64();
            if (c == stall) begin
                i_mem_memoryed_ack = 1'b1;
                i_mem_executed_req = 1'b0;
            end
            tick();
        end
        i_mem_memoryed_ack = 1'b0;
        i_dmem_ready = 1'b0;
        check("back_idle_wb_req", o_mem_memoryed_req, 0);
        check("back_idle_exec_ack", o_mem_executed_ack, 1);
        check("back_idle_wdata", o_mem_rd_wdata, 0);
        check("back_idle_pc", o_mem_pc, 0);
    endtask

    initial begin
        #2;
        check("rst_exec_ack", o_mem_executed_ack, 1);
        check("rst_dmem_req", o_dmem_req, 0);
        check("rst_wb_req", o_mem_memoryed_req, 0);
        check("rst_pc", o_mem_pc, 0);
        check("rst_wdata", o_mem_rd_wdata, 0);
        check("rst_intr", o_mem_intrNo, 0);
        tick();
        rst = 1'b1;
        tick();

        // ALU op, loads, stores and the misaligned/latency/backpressure corners
        run_txn(0, 0, 3'b011, 64'h0, 64'h0, 64'h1234, 64'h0, 64'h8000_0000, 5'd5, 1, 0);
        run_txn(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 64'h8000_0004, 5'd6, 1, 0);
        check("lb_sign_value", o_mem_rd_wdata, 0);
        run_txn(1, 0, 3'b100, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 64'h8000_0008, 5'd7, 2, 0);
        run_txn(0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'h55, 64'h0, 64'h8000_000C, 5'd8, 1, 0);
        run_txn(0, 1, 3'b010, 64'h2006, 64'hDEAD_BEEF, 64'h66, 64'h0, 64'h8000_0010, 5'd9, 1, 0);
        run_txn(1, 0, 3'b011, 64'h3000, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h8000_0014, 5'd10, 4, 0);
        run_txn(1, 0, 3'b010, 64'h3004, 64'h0, 64'h0, 64'hF000_0000_0000_0000, 64'h8000_0018, 5'd11, 1, 3);
        run_txn(1, 1, 3'b011, 64'h4000, 64'hAA, 64'h77, 64'h0, 64'h8000_001C, 5'd12, 2, 1);

        for (int i = 0; i < 150; i++) begin
            int unsigned kind = $urandom_range(0, 3);
            run_txn(1'(kind == 1 || kind == 3), 1'(kind >= 2), 3'($urandom), rnd64(),
                    rnd64(), rnd64(), rnd64(), rnd64(), 5'($urandom),
                    $urandom_range(1, 5), $urandom_range(0, 3));
        end

        // asynchronous reset in the middle of an access
        i_mem_pc = 64'h9000_0000; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
        i_mem_addr = 64'h5000; i_mem_funct3 = 3'b011; i_mem_executed_req = 1'b1;
        tick();
        i_mem_executed_req = 1'b0;
        check("pre_rst_dmem_req", o_dmem_req, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_dmem_req", o_dmem_req, 0);
        check("async_rst_wb_req", o_mem_memoryed_req, 0);
        check("async_rst_pc", o_mem_pc, 0);
        check("async_rst_exec_ack", o_mem_executed_ack, 1);
        tick();
        rst = 1'b1;
        i_dmem_ready = 1'b1;
        i_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        i_dmem_ready = 1'b0;
        check("late_ready_wb_req", o_mem_memoryed_req, 0);
        check("late_ready_dmem_req", o_dmem_req, 0);
        check("late_ready_exec_ack", o_mem_executed_ack, 1);
        tick();
        check("late_ready_wb_req2", o_mem_memoryed_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
